// File: rtl/instr_queue_if.sv
// Handshake and status bundle between the instruction source, the instruction queue
// and the controller that drains it.
interface instr_queue_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 6
);
    logic                  flush;
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_ready;
    logic [ADDR_WIDTH:0]   count;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  overflow;

    // Producer/consumer side drives the handshake inputs and observes the status.
    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count, full, empty, almost_full, overflow
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count, full, empty, almost_full, overflow
    );
endinterface

// File: rtl/instr_queue.sv
// Single-clock first-word-fall-through instruction FIFO with flush, occupancy,
// almost-full reporting and a sticky overflow flag.
module instr_queue #(
    parameter int unsigned DATA_WIDTH   = 64,
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned AFULL_THRESH = 56
) (
    input  logic          clk,
    input  logic          rst,
    instr_queue_if.slave  q
);
    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0]  count_q;
    logic                  overflow_q;

    logic full_c;
    logic empty_c;
    logic push_c;
    logic pop_c;

    // Status decodes straight from the occupancy register.
    assign full_c  = (count_q == CNT_WIDTH'(DEPTH));
    assign empty_c = (count_q == '0);

    // Flush swallows any handshake that happens in the same cycle.
    assign push_c = q.in_valid  && !full_c  && !q.flush;
    assign pop_c  = q.out_ready && !empty_c && !q.flush;

    assign q.in_ready    = !full_c;
    assign q.out_valid   = !empty_c;
    assign q.out_data    = mem[rd_ptr];
    assign q.count       = count_q;
    assign q.full        = full_c;
    assign q.empty       = empty_c;
    assign q.almost_full = (count_q >= CNT_WIDTH'(AFULL_THRESH));
    assign q.overflow    = overflow_q;

    // Storage is never reset or cleared; only pointers define validity.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= q.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (q.flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            if (push_c && !pop_c) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end else if (pop_c && !push_c) begin
                count_q <= count_q - CNT_WIDTH'(1);
            end
            if (q.in_valid && full_c) begin
                overflow_q <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_instr_queue.sv
// Randomized bench for instr_queue, checked against a queue-based reference model.
module tb_instr_queue;
    localparam int unsigned DATA_WIDTH   = 64;
    localparam int unsigned DEPTH        = 64;
    localparam int unsigned ADDR_WIDTH   = 6;
    localparam int unsigned AFULL_THRESH = 56;

    logic clk;
    logic rst;

    instr_queue_if #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) q_if ();

    instr_queue #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH       (DEPTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .AFULL_THRESH(AFULL_THRESH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .q  (q_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [DATA_WIDTH-1:0] mq [$];
    bit                    m_ovf = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_WIDTH-1:0] rand_data();
        return {$urandom(), $urandom()};
    endfunction

    task automatic check_outputs();
        int sz;
        sz = mq.size();
        chk("count",       64'(q_if.count),       64'(sz));
        chk("full",        64'(q_if.full),        64'(sz == DEPTH));
        chk("empty",       64'(q_if.empty),       64'(sz == 0));
        chk("almost_full", 64'(q_if.almost_full), 64'(sz >= AFULL_THRESH));
        chk("in_ready",    64'(q_if.in_ready),    64'(sz != DEPTH));
        chk("out_valid",   64'(q_if.out_valid),   64'(sz != 0));
        chk("overflow",    64'(q_if.overflow),    64'(m_ovf));
        if (sz != 0) chk("out_data", q_if.out_data, mq[0]);
    endtask

    // One clock: predict from the inputs presented, advance the model, compare.
    task automatic step();
        bit                    m_full;
        bit                    do_push;
        bit                    do_pop;
        bit                    fl;
        bit                    iv;
        logic [DATA_WIDTH-1:0] d;
        m_full  = (mq.size() == DEPTH);
        iv      = q_if.in_valid;
        fl      = q_if.flush;
        d       = q_if.in_data;
        do_push = iv && !m_full;
        do_pop  = q_if.out_ready && (mq.size() != 0);
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            if (iv && m_full) m_ovf = 1'b1;
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(d);
        end
        check_outputs();
    endtask

    task automatic idle_inputs();
        q_if.flush     = 1'b0;
        q_if.in_valid  = 1'b0;
        q_if.in_data   = '0;
        q_if.out_ready = 1'b0;
    endtask

    task automatic push_n(input int n);
        q_if.out_ready = 1'b0;
        for (int i = 0; i < n; i++) begin
            q_if.in_valid = 1'b1;
            q_if.in_data  = rand_data();
            step();
        end
        q_if.in_valid = 1'b0;
    endtask

    initial begin
        logic [DATA_WIDTH-1:0] flush_data;
        logic [DATA_WIDTH-1:0] first_data;

        idle_inputs();
        rst = 1'b0;
        #1;
        check_outputs();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // Fill with 1..64, consumer stalled.
        for (int i = 1; i <= DEPTH; i++) begin
            q_if.in_valid = 1'b1;
            q_if.in_data  = DATA_WIDTH'(i);
            step();
        end
        q_if.in_valid = 1'b0;
        chk("filled_count", 64'(q_if.count), 64'(DEPTH));

        // Drain in order.
        q_if.out_ready = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            chk("drain_data", q_if.out_data, 64'(i));
            step();
        end
        q_if.out_ready = 1'b0;
        chk("drained_empty", 64'(q_if.empty), 64'(1));

        // Steady-state push+pop across pointer wrap.
        push_n(10);
        q_if.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            q_if.in_valid = 1'b1;
            q_if.in_data  = rand_data();
            step();
            chk("stream_count", 64'(q_if.count), 64'(10));
        end
        idle_inputs();

        // Full with simultaneous pop: push refused, then accepted next cycle.
        push_n(DEPTH - 10);
        q_if.in_valid  = 1'b1;
        q_if.in_data   = rand_data();
        q_if.out_ready = 1'b1;
        step();
        chk("full_pop_count", 64'(q_if.count), 64'(DEPTH - 1));
        q_if.out_ready = 1'b0;
        step();
        chk("retry_count", 64'(q_if.count), 64'(DEPTH));
        chk("overflow_set", 64'(q_if.overflow), 64'(1));
        idle_inputs();

        // Drain to 20, then flush with a push pending.
        q_if.out_ready = 1'b1;
        repeat (DEPTH - 20) step();
        q_if.out_ready = 1'b0;
        chk("pre_flush_count", 64'(q_if.count), 64'(20));
        flush_data     = rand_data();
        q_if.flush     = 1'b1;
        q_if.in_valid  = 1'b1;
        q_if.in_data   = flush_data;
        step();
        q_if.flush     = 1'b0;
        q_if.in_valid  = 1'b0;
        chk("flush_count", 64'(q_if.count), 64'(0));
        chk("flush_ovf",   64'(q_if.overflow), 64'(0));
        push_n(1);
        chk("post_flush_not_stale", 64'(q_if.out_data == flush_data), 64'(0));

        // Random traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            q_if.in_valid  = ($urandom_range(0, 3) != 0);
            q_if.out_ready = ($urandom_range(0, 2) == 0);
            q_if.flush     = ($urandom_range(0, 63) == 0);
            q_if.in_data   = rand_data();
            step();
        end
        idle_inputs();

        // Asynchronous reset mid-traffic at count 33.
        q_if.flush = 1'b1;
        step();
        q_if.flush = 1'b0;
        push_n(33);
        chk("pre_reset_count", 64'(q_if.count), 64'(33));
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        mq.delete();
        m_ovf = 1'b0;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        first_data    = rand_data();
        q_if.in_valid = 1'b1;
        q_if.in_data  = first_data;
        step();
        q_if.in_valid = 1'b0;
        chk("post_reset_data",  q_if.out_data, first_data);
        chk("post_reset_valid", 64'(q_if.out_valid), 64'(1));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
